// File: rtl/dc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dc_arb_pkg
// Description : Shared types and AXI constant fields for the two-requester
//               AXI read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dc_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    // Requester index: 0 = layer-0 fetch, 1 = second layer / cursor fetch
    typedef logic req_idx_t;

    // Fixed AR channel fields
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic       AXI_LOCK_NONE   = 1'b0;
    localparam logic [3:0] AXI_CACHE_NONE  = 4'h0;
    localparam logic [2:0] AXI_PROT_NONE   = 3'h0;
    localparam logic [3:0] AXI_QOS_NONE    = 4'h0;
    localparam logic [3:0] AXI_REGION_NONE = 4'h0;

endpackage : dc_arb_pkg
`default_nettype wire

// File: rtl/dc_rr_grant2.sv
`default_nettype none
// ============================================================================
// Module      : dc_rr_grant2
// Description : Two-way grant selector. Produces a one-hot grant from the
//               eligibility vector, using either round-robin (the requester
//               that did not win last time wins a tie) or fixed priority
//               with requester 0 highest.
// Revision    : 1.0 - initial release
// ============================================================================
module dc_rr_grant2
    import dc_arb_pkg::*;
#(
    parameter bit PRIORITY_MODE = 1'b0
) (
    input  logic [1:0] i_elig,
    input  req_idx_t   i_last_grant,
    output logic [1:0] o_grant
);

    // Resolve ties; a single eligible requester is always granted
    always_comb begin
        o_grant = 2'b00;
        if (i_elig == 2'b11) begin
            if (PRIORITY_MODE || (i_last_grant == 1'b1)) begin
                o_grant = 2'b01;
            end else begin
                o_grant = 2'b10;
            end
        end else begin
            o_grant = i_elig;
        end
    end

endmodule : dc_rr_grant2
`default_nettype wire

// File: rtl/dc_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dc_axi_read_arbiter
// Description : Shares one AXI read master between two fetch requesters.
//               Arbitrates AR requests, tags each burst with an ID whose
//               LSB is the requester index, routes R beats back by ID and
//               tracks outstanding bursts per requester. Beats that match
//               no requester with outstanding work are drained and flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module dc_axi_read_arbiter
    import dc_arb_pkg::*;
#(
    parameter int         AXI_ARADDR_WIDTH = 32,
    parameter int         AXI_DATA_WIDTH   = 16,
    parameter logic [2:0] READ_DATA_SIZE   = 3'd1,
    parameter int         MAX_OUTSTANDING  = 4,
    parameter logic [6:0] ID_BASE          = 7'h0,
    parameter bit         PRIORITY_MODE    = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    // Requester 0
    input  logic [AXI_ARADDR_WIDTH-1:0] s0_araddr,
    input  logic [7:0]                  s0_arlen,
    input  logic                        s0_arvalid,
    output logic                        s0_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s0_rdata,
    output logic [1:0]                  s0_rresp,
    output logic                        s0_rlast,
    output logic                        s0_rvalid,
    input  logic                        s0_rready,
    // Requester 1
    input  logic [AXI_ARADDR_WIDTH-1:0] s1_araddr,
    input  logic [7:0]                  s1_arlen,
    input  logic                        s1_arvalid,
    output logic                        s1_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s1_rdata,
    output logic [1:0]                  s1_rresp,
    output logic                        s1_rlast,
    output logic                        s1_rvalid,
    input  logic                        s1_rready,
    // AXI master AR channel
    output logic [7:0]                  m_axi_arid,
    output logic [AXI_ARADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic                        m_axi_arlock,
    output logic [3:0]                  m_axi_arcache,
    output logic [2:0]                  m_axi_arprot,
    output logic [3:0]                  m_axi_arqos,
    output logic [3:0]                  m_axi_arregion,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    // AXI master R channel
    input  logic [7:0]                  m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    // Status
    output logic                        idle,
    output logic                        err_orphan
);

    localparam int                c_cnt_w   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_OUTSTANDING);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    arb_state_t                  r_state;
    arb_state_t                  w_state_next;
    req_idx_t                    r_last_grant;
    req_idx_t                    r_gidx;
    logic [AXI_ARADDR_WIDTH-1:0] r_araddr;
    logic [7:0]                  r_arlen;
    logic [7:0]                  r_arid;
    logic [c_cnt_w-1:0]          r_cnt0;
    logic [c_cnt_w-1:0]          r_cnt1;
    logic                        r_err_orphan;

    logic [1:0] w_elig;
    logic [1:0] w_grant;
    logic       w_load;
    logic       w_accept;
    logic       w_hit0;
    logic       w_hit1;
    logic       w_orphan;
    logic       w_inc0;
    logic       w_inc1;
    logic       w_dec0;
    logic       w_dec1;

    // A requester at its outstanding limit is not eligible
    assign w_elig[0] = s0_arvalid && (r_cnt0 < c_cnt_max);
    assign w_elig[1] = s1_arvalid && (r_cnt1 < c_cnt_max);

    dc_rr_grant2 #(
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_grant (
        .i_elig       (w_elig),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // FSM state register; state only advances while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (en) begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: IDLE captures a winner, ISSUE waits for the fabric
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_accept     = 1'b0;
        if (en) begin
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        w_load       = 1'b1;
                        w_state_next = ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_axi_arready) begin
                        w_accept     = 1'b1;
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Capture the granted request; remember the winner once the AR is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arid       <= {ID_BASE, 1'b0};
            r_gidx       <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_load) begin
                r_araddr <= w_grant[1] ? s1_araddr : s0_araddr;
                r_arlen  <= w_grant[1] ? s1_arlen : s0_arlen;
                r_arid   <= {ID_BASE, w_grant[1]};
                r_gidx   <= w_grant[1];
            end
            if (w_accept) begin
                r_last_grant <= r_gidx;
            end
        end
    end

    // Requester handshake is the single IDLE cycle in which it is captured
    assign s0_arready = w_load && w_grant[0];
    assign s1_arready = w_load && w_grant[1];

    assign m_axi_arid     = r_arid;
    assign m_axi_araddr   = r_araddr;
    assign m_axi_arlen    = r_arlen;
    assign m_axi_arsize   = READ_DATA_SIZE;
    assign m_axi_arburst  = AXI_BURST_INCR;
    assign m_axi_arlock   = AXI_LOCK_NONE;
    assign m_axi_arcache  = AXI_CACHE_NONE;
    assign m_axi_arprot   = AXI_PROT_NONE;
    assign m_axi_arqos    = AXI_QOS_NONE;
    assign m_axi_arregion = AXI_REGION_NONE;
    assign m_axi_arvalid  = (r_state == ISSUE);

    // A beat belongs to a requester only if its ID matches and it has bursts in flight
    assign w_hit0   = m_axi_rvalid && (m_axi_rid[7:1] == ID_BASE) && !m_axi_rid[0] && (r_cnt0 != '0);
    assign w_hit1   = m_axi_rvalid && (m_axi_rid[7:1] == ID_BASE) &&  m_axi_rid[0] && (r_cnt1 != '0);
    assign w_orphan = m_axi_rvalid && !w_hit0 && !w_hit1;

    assign s0_rvalid = w_hit0;
    assign s1_rvalid = w_hit1;
    assign s0_rdata  = m_axi_rdata;
    assign s1_rdata  = m_axi_rdata;
    assign s0_rresp  = m_axi_rresp;
    assign s1_rresp  = m_axi_rresp;
    assign s0_rlast  = m_axi_rlast;
    assign s1_rlast  = m_axi_rlast;

    // Orphan beats are always accepted so they cannot wedge the fabric
    assign m_axi_rready = w_hit0 ? s0_rready : (w_hit1 ? s1_rready : 1'b1);

    assign w_inc0 = w_accept && (r_gidx == 1'b0);
    assign w_inc1 = w_accept && (r_gidx == 1'b1);
    assign w_dec0 = en && w_hit0 && s0_rready && m_axi_rlast;
    assign w_dec1 = en && w_hit1 && s1_rready && m_axi_rlast;

    // Outstanding-burst counters; a simultaneous issue and completion cancel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (en) begin
            case ({w_inc0, w_dec0})
                2'b10:   r_cnt0 <= r_cnt0 + c_cnt_one;
                2'b01:   r_cnt0 <= r_cnt0 - c_cnt_one;
                default: r_cnt0 <= r_cnt0;
            endcase
            case ({w_inc1, w_dec1})
                2'b10:   r_cnt1 <= r_cnt1 + c_cnt_one;
                2'b01:   r_cnt1 <= r_cnt1 - c_cnt_one;
                default: r_cnt1 <= r_cnt1;
            endcase
        end
    end

    // Sticky orphan flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_orphan <= 1'b0;
        end else if (en && w_orphan) begin
            r_err_orphan <= 1'b1;
        end
    end

    assign err_orphan = r_err_orphan;
    assign idle       = (r_state == IDLE) && (r_cnt0 == '0) && (r_cnt1 == '0);

endmodule : dc_axi_read_arbiter
`default_nettype wire

// File: tb/tb_dc_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dc_axi_read_arbiter
// Description : Directed self-checking bench for dc_axi_read_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dc_axi_read_arbiter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] s0_araddr, s1_araddr;
    logic [7:0]  s0_arlen, s1_arlen;
    logic        s0_arvalid, s1_arvalid;
    logic        s0_arready, s1_arready;
    logic [15:0] s0_rdata, s1_rdata;
    logic [1:0]  s0_rresp, s1_rresp;
    logic        s0_rlast, s1_rlast;
    logic        s0_rvalid, s1_rvalid;
    logic        s0_rready, s1_rready;
    logic [7:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic [3:0]  m_axi_arregion;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [7:0]  m_axi_rid;
    logic [15:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic        idle;
    logic        err_orphan;

    int checks = 0;
    int errors = 0;

    dc_axi_read_arbiter #(
        .AXI_ARADDR_WIDTH (32),
        .AXI_DATA_WIDTH   (16),
        .READ_DATA_SIZE   (3'd1),
        .MAX_OUTSTANDING  (4),
        .ID_BASE          (7'h0),
        .PRIORITY_MODE    (1'b0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .s0_araddr      (s0_araddr),
        .s0_arlen       (s0_arlen),
        .s0_arvalid     (s0_arvalid),
        .s0_arready     (s0_arready),
        .s0_rdata       (s0_rdata),
        .s0_rresp       (s0_rresp),
        .s0_rlast       (s0_rlast),
        .s0_rvalid      (s0_rvalid),
        .s0_rready      (s0_rready),
        .s1_araddr      (s1_araddr),
        .s1_arlen       (s1_arlen),
        .s1_arvalid     (s1_arvalid),
        .s1_arready     (s1_arready),
        .s1_rdata       (s1_rdata),
        .s1_rresp       (s1_rresp),
        .s1_rlast       (s1_rlast),
        .s1_rvalid      (s1_rvalid),
        .s1_rready      (s1_rready),
        .m_axi_arid     (m_axi_arid),
        .m_axi_araddr   (m_axi_araddr),
        .m_axi_arlen    (m_axi_arlen),
        .m_axi_arsize   (m_axi_arsize),
        .m_axi_arburst  (m_axi_arburst),
        .m_axi_arlock   (m_axi_arlock),
        .m_axi_arcache  (m_axi_arcache),
        .m_axi_arprot   (m_axi_arprot),
        .m_axi_arqos    (m_axi_arqos),
        .m_axi_arregion (m_axi_arregion),
        .m_axi_arvalid  (m_axi_arvalid),
        .m_axi_arready  (m_axi_arready),
        .m_axi_rid      (m_axi_rid),
        .m_axi_rdata    (m_axi_rdata),
        .m_axi_rresp    (m_axi_rresp),
        .m_axi_rlast    (m_axi_rlast),
        .m_axi_rvalid   (m_axi_rvalid),
        .m_axi_rready   (m_axi_rready),
        .idle           (idle),
        .err_orphan     (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stable;
        logic extra_rdy;

        rst = 1'b1; en = 1'b1;
        s0_araddr = '0; s0_arlen = '0; s0_arvalid = 1'b0; s0_rready = 1'b1;
        s1_araddr = '0; s1_arlen = '0; s1_arvalid = 1'b0; s1_rready = 1'b1;
        m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
        m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_arid", m_axi_arid, 8'h00);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_arlen", m_axi_arlen, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err", err_orphan, 0);
        chk("rst_s0_arready", s0_arready, 0);
        chk("rst_rready", m_axi_rready, 1);
        rst = 1'b0;
        tick();

        // Single s0 burst of 16 beats
        s0_araddr = 32'h1000; s0_arlen = 8'd15; s0_arvalid = 1'b1;
        #1;
        chk("t1_s0_arready", s0_arready, 1);
        chk("t1_s1_arready", s1_arready, 0);
        tick();
        s0_arvalid = 1'b0;
        #1;
        chk("t1_arvalid", m_axi_arvalid, 1);
        chk("t1_araddr", m_axi_araddr, 32'h1000);
        chk("t1_arlen", m_axi_arlen, 15);
        chk("t1_arid", m_axi_arid, 8'h00);
        chk("t1_arsize", m_axi_arsize, 1);
        chk("t1_arburst", m_axi_arburst, 2'b01);
        chk("t1_idle_busy", idle, 0);
        chk("t1_no_repulse", s0_arready, 0);
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        #1;
        chk("t1_arvalid_drop", m_axi_arvalid, 0);
        chk("t1_idle_outst", idle, 0);
        for (int i = 0; i < 16; i++) begin
            m_axi_rvalid = 1'b1; m_axi_rid = 8'h00;
            m_axi_rdata = 16'hA000 + 16'(i); m_axi_rlast = (i == 15);
            #1;
            if (i == 0 || i == 15) begin
                chk("t1_s0_rvalid", s0_rvalid, 1);
                chk("t1_s1_rvalid", s1_rvalid, 0);
                chk("t1_s0_rdata", s0_rdata, 16'hA000 + 16'(i));
                chk("t1_s0_rlast", s0_rlast, (i == 15));
            end
            tick();
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        #1;
        chk("t1_idle_done", idle, 1);
        chk("t1_err", err_orphan, 0);

        // s1 AR with arready held low for 10 cycles
        s1_araddr = 32'h2000; s1_arlen = 8'd3; s1_arvalid = 1'b1;
        #1;
        chk("t4_s1_arready", s1_arready, 1);
        chk("t4_s0_arready", s0_arready, 0);
        tick();
        stable = 1'b1; extra_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stable = stable & (m_axi_araddr == 32'h2000) & (m_axi_arlen == 8'd3)
                            & (m_axi_arid == 8'h01) & m_axi_arvalid;
            extra_rdy = extra_rdy | s0_arready | s1_arready;
            tick();
        end
        chk("t4_stable", stable, 1);
        chk("t4_no_second_rdy", extra_rdy, 0);
        s1_arvalid = 1'b0; m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_axi_rvalid = 1'b1; m_axi_rid = 8'h01; m_axi_rlast = (i == 3);
            #1;
            if (i == 0) begin
                chk("t4_s1_rvalid", s1_rvalid, 1);
                chk("t4_s0_rvalid", s0_rvalid, 0);
            end
            tick();
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        #1;
        chk("t4_idle", idle, 1);

        // Round-robin with both requesting; last winner was s1 so s0 goes first
        s0_araddr = 32'h3000; s1_araddr = 32'h4000;
        s0_arvalid = 1'b1; s1_arvalid = 1'b1; m_axi_arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_rr_s0", s0_arready, (i % 2) == 0);
            chk("t2_rr_s1", s1_arready, (i % 2) == 1);
            tick();
            chk("t2_arid", m_axi_arid, 8'(i % 2));
            tick();
        end

        // s0 alone fills to 4 outstanding, then s1 still gets through
        s1_arvalid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            #1;
            chk("t3_s0_fill", s0_arready, 1);
            tick(); tick();
        end
        #1;
        chk("t3_s0_full", s0_arready, 0);
        tick();
        chk("t3_no_arvalid", m_axi_arvalid, 0);
        s1_arvalid = 1'b1;
        #1;
        chk("t3_s1_turn", s1_arready, 1);
        tick(); tick();
        #1;
        chk("t3_s1_override", s1_arready, 1);
        chk("t3_s0_blocked", s0_arready, 0);
        tick(); tick();
        #1;
        chk("t3_both_full", {s0_arready, s1_arready}, 2'b00);
        m_axi_rvalid = 1'b1; m_axi_rid = 8'h00; m_axi_rlast = 1'b1;
        #1;
        chk("t3_one_last", s0_rvalid, 1);
        tick();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        #1;
        chk("t3_fifth_ar", s0_arready, 1);
        tick(); tick();
        s0_arvalid = 1'b0; s1_arvalid = 1'b0; m_axi_arready = 1'b0;

        // Backpressure on a hit, then an orphan beat
        m_axi_rvalid = 1'b1; m_axi_rid = 8'h00; s0_rready = 1'b0;
        #1;
        chk("t5_hit_bp", m_axi_rready, 0);
        chk("t5_hit_valid", s0_rvalid, 1);
        m_axi_rid = 8'h7E; s1_rready = 1'b0;
        #1;
        chk("t5_orphan_rready", m_axi_rready, 1);
        chk("t5_orphan_s0", s0_rvalid, 0);
        chk("t5_orphan_s1", s1_rvalid, 0);
        tick();
        m_axi_rvalid = 1'b0;
        #1;
        chk("t5_err_set", err_orphan, 1);
        tick(); tick();
        chk("t5_err_sticky", err_orphan, 1);
        s0_rready = 1'b1; s1_rready = 1'b1;

        // Reset in the middle of an s0 burst, then replay the tail
        for (int i = 0; i < 3; i++) begin
            m_axi_rvalid = 1'b1; m_axi_rid = 8'h00; m_axi_rlast = 1'b0;
            tick();
        end
        m_axi_rvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_rst_err", err_orphan, 0);
        chk("t6_rst_idle", idle, 1);
        tick();
        rst = 1'b0;
        s0_rready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            m_axi_rvalid = 1'b1; m_axi_rid = 8'h00; m_axi_rlast = (i == 12);
            #1;
            if (i == 0) begin
                chk("t6_drain_s0", s0_rvalid, 0);
                chk("t6_drain_rready", m_axi_rready, 1);
            end
            tick();
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s0_rready = 1'b1;
        #1;
        chk("t6_err", err_orphan, 1);
        chk("t6_idle", idle, 1);

        // Clock enable low freezes arbitration; first grant after reset is s0
        en = 1'b0; s0_arvalid = 1'b1; s1_arvalid = 1'b1;
        #1;
        chk("en_low_rdy", s0_arready, 0);
        tick();
        chk("en_low_arvalid", m_axi_arvalid, 0);
        en = 1'b1;
        #1;
        chk("t6_first_s0", s0_arready, 1);
        chk("t6_first_s1", s1_arready, 0);
        tick();
        chk("t6_first_arid", m_axi_arid, 8'h00);
        chk("t6_first_addr", m_axi_araddr, 32'h3000);
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dc_axi_read_arbiter
`default_nettype wire
